stall_flush_controller: RTL and testbench

Pipeline sequencing block for the 5-stage RISC-V core. It consumes the stall request from the ID-stage hazard detector, branch/jump mispredictions resolved in EX, halt (ECALL, x17==10) detection in EX, and a busy signal from the multi-cycle data memory. It produces every per-stage write-enable and flush. It owns the halt-drain sequence and the stall/flush performance counters.

---
 rtl/stall_flush_controller_pkg.sv | 42 ++++
 rtl/stall_flush_controller_if.sv | 36 +++
 rtl/stall_flush_controller_sat_counter.sv | 23 ++
 rtl/stall_flush_controller.sv | 124 ++++++++++++
 tb/tb_stall_flush_controller.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/stall_flush_controller_pkg.sv
// Shared definitions for the pipeline sequencing block: FSM encoding, the opcodes the
// halt detector keys on, and the bubble contents loaded by flushed pipeline registers.
package stall_flush_controller_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StDrain   = 2'd2,
        StHalted  = 2'd3
    } state_e;

    localparam logic [6:0]  OpcodeLoad   = 7'b0000011;
    localparam logic [6:0]  OpcodeStore  = 7'b0100011;
    localparam logic [6:0]  OpcodeBranch = 7'b1100011;
    localparam logic [6:0]  OpcodeJal    = 7'b1101111;
    localparam logic [6:0]  OpcodeJalr   = 7'b1100111;
    localparam logic [6:0]  OpcodeSystem = 7'b1110011;
    localparam logic [31:0] InstrEcall   = 32'h0000_0073;
    localparam logic [4:0]  HaltReg      = 5'd17;
    localparam logic [31:0] HaltCode     = 32'd10;

    // A bubble is an addi x0,x0,0 with every control bit cleared.
    localparam logic [31:0] InstrNop = 32'h0000_0013;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
        logic jump;
        logic alu_src;
        logic halt;
    } ctrl_t;

    localparam ctrl_t CtrlBubble = '0;

    function automatic logic is_halt_ecall(input logic [31:0] instr, input logic [31:0] a7);
        return (instr == InstrEcall) && (a7 == HaltCode);
    endfunction

endpackage

// File: rtl/stall_flush_controller_if.sv
// Request/enable bundle between the pipeline datapath and the sequencing controller.
// The controller side (master) drives enables, flushes and counters.
interface stall_flush_controller_if #(
    parameter int unsigned COUNTER_WIDTH = 32
);
    logic                     is_hazard;
    logic                     ex_mispredict;
    logic                     ex_halt;
    logic                     dmem_busy;
    logic                     pc_write;
    logic                     if_id_write;
    logic                     id_ex_write;
    logic                     ex_mem_write;
    logic                     if_id_flush;
    logic                     id_ex_flush;
    logic                     mem_wb_flush;
    logic                     is_halted;
    logic [COUNTER_WIDTH-1:0] cycle_count;
    logic [COUNTER_WIDTH-1:0] stall_count;
    logic [COUNTER_WIDTH-1:0] flush_count;

    modport master (
        input  is_hazard, ex_mispredict, ex_halt, dmem_busy,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
        output if_id_flush, id_ex_flush, mem_wb_flush,
        output is_halted, cycle_count, stall_count, flush_count
    );

    modport slave (
        output is_hazard, ex_mispredict, ex_halt, dmem_busy,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
        input  if_id_flush, id_ex_flush, mem_wb_flush,
        input  is_halted, cycle_count, stall_count, flush_count
    );

endinterface

// File: rtl/stall_flush_controller_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module stall_flush_controller_sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stall_flush_controller.sv
// Pipeline sequencing: per-stage write enables and flushes, halt-drain FSM and
// stall/flush performance counters for the 5-stage core.
module stall_flush_controller
    import stall_flush_controller_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned DRAIN_CYCLES  = 2
) (
    input logic                          clk,
    input logic                          reset,
    stall_flush_controller_if.master     bus
);

    localparam int unsigned DrainWidth = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DrainWidth-1:0] DrainLoad = DrainWidth'(DRAIN_CYCLES);

    state_e                state_q;
    logic [DrainWidth-1:0] drain_q;
    logic                  is_halted_q;

    logic active, busy_freeze, halt_start, drain_step, flush_apply, hazard_apply;

    always_comb begin
        active       = (state_q == StRun) || (state_q == StMemWait);
        busy_freeze  = bus.dmem_busy && (state_q != StHalted);
        halt_start   = active && !bus.dmem_busy && bus.ex_halt;
        drain_step   = (state_q == StDrain) && !bus.dmem_busy;
        flush_apply  = active && !bus.dmem_busy && !bus.ex_halt && bus.ex_mispredict;
        // A mispredict squashes the stalled instruction, so the hazard is dropped.
        hazard_apply = active && !bus.dmem_busy && !bus.ex_halt && !bus.ex_mispredict &&
                       bus.is_hazard;
    end

    always_comb begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.id_ex_write  = 1'b1;
        bus.ex_mem_write = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.mem_wb_flush = 1'b0;
        if (state_q == StHalted) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_write  = 1'b0;
            bus.ex_mem_write = 1'b0;
        end else if (busy_freeze) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_write  = 1'b0;
            bus.ex_mem_write = 1'b0;
            bus.mem_wb_flush = 1'b1;
        end else if (halt_start || drain_step) begin
            bus.pc_write    = 1'b0;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (flush_apply) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (hazard_apply) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            drain_q     <= '0;
            is_halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun, StMemWait: begin
                    if (bus.dmem_busy) begin
                        state_q <= StMemWait;
                    end else if (bus.ex_halt) begin
                        state_q <= StDrain;
                        drain_q <= DrainLoad;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StDrain: begin
                    if (!bus.dmem_busy) begin
                        drain_q <= drain_q - DrainWidth'(1);
                        if (drain_q == DrainWidth'(1)) begin
                            state_q     <= StHalted;
                            is_halted_q <= 1'b1;
                        end
                    end
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.is_halted = is_halted_q;

    stall_flush_controller_sat_counter #(.Width(COUNTER_WIDTH)) u_cycle_count (
        .clk   (clk),
        .reset (reset),
        .inc   (state_q != StHalted),
        .count (bus.cycle_count)
    );

    stall_flush_controller_sat_counter #(.Width(COUNTER_WIDTH)) u_stall_count (
        .clk   (clk),
        .reset (reset),
        .inc   (busy_freeze || hazard_apply),
        .count (bus.stall_count)
    );

    stall_flush_controller_sat_counter #(.Width(COUNTER_WIDTH)) u_flush_count (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_apply),
        .count (bus.flush_count)
    );

endmodule

// File: tb/tb_stall_flush_controller.sv
// Directed bench for stall_flush_controller: stall, flush, busy freeze, halt drain,
// asynchronous reset and counter saturation (second instance with 4-bit counters).
module tb_stall_flush_controller;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    stall_flush_controller_if #(.COUNTER_WIDTH(32)) sfc_if ();
    stall_flush_controller_if #(.COUNTER_WIDTH(4))  sfc4_if ();

    stall_flush_controller #(.COUNTER_WIDTH(32), .DRAIN_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sfc_if)
    );

    stall_flush_controller #(.COUNTER_WIDTH(4), .DRAIN_CYCLES(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (sfc4_if)
    );

    // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_flush}
    localparam logic [6:0] OutDef   = 7'b1111000;
    localparam logic [6:0] OutHaz   = 7'b0011010;
    localparam logic [6:0] OutMisp  = 7'b1111110;
    localparam logic [6:0] OutBusy  = 7'b0000001;
    localparam logic [6:0] OutDrain = 7'b0111110;
    localparam logic [6:0] OutHalt  = 7'b0000000;

    logic [6:0] outs;
    assign outs = {sfc_if.pc_write, sfc_if.if_id_write, sfc_if.id_ex_write, sfc_if.ex_mem_write,
                   sfc_if.if_id_flush, sfc_if.id_ex_flush, sfc_if.mem_wb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic haz, input logic misp, input logic halt, input logic busy);
        sfc_if.is_hazard     = haz;
        sfc_if.ex_mispredict = misp;
        sfc_if.ex_halt       = halt;
        sfc_if.dmem_busy     = busy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        sfc4_if.is_hazard     = 1'b0;
        sfc4_if.ex_mispredict = 1'b0;
        sfc4_if.ex_halt       = 1'b0;
        sfc4_if.dmem_busy     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_outs", 32'(outs), 32'(OutDef));
        check("rst_cycle", sfc_if.cycle_count, 32'd0);
        check("rst_stall", sfc_if.stall_count, 32'd0);
        check("rst_flush", sfc_if.flush_count, 32'd0);
        check("rst_halted", 32'(sfc_if.is_halted), 32'd0);

        // Single-cycle load-use stall
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("haz_outs", 32'(outs), 32'(OutHaz));
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("haz_cycle", sfc_if.cycle_count, 32'd1);
        check("haz_stall", sfc_if.stall_count, 32'd1);
        check("haz_release_outs", 32'(outs), 32'(OutDef));

        // Mispredict wins over a simultaneous hazard
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("misp_haz_outs", 32'(outs), 32'(OutMisp));
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("misp_flush", sfc_if.flush_count, 32'd1);
        check("misp_stall", sfc_if.stall_count, 32'd1);

        // Busy memory holds off a pending mispredict for three cycles
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 check("busy_outs", 32'(outs), 32'(OutBusy));
            step();
        end
        check("busy_flush_held", sfc_if.flush_count, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("busy_release_outs", 32'(outs), 32'(OutMisp));
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("busy_stall", sfc_if.stall_count, 32'd4);
        check("busy_flush", sfc_if.flush_count, 32'd2);
        check("busy_cycle", sfc_if.cycle_count, 32'd6);

        // Halt drain with no busy cycles
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        #1 check("halt_start_outs", 32'(outs), 32'(OutDrain));
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("drain1_outs", 32'(outs), 32'(OutDrain));
        check("drain1_halted", 32'(sfc_if.is_halted), 32'd0);
        step();
        check("drain2_outs", 32'(outs), 32'(OutDrain));
        check("drain2_halted", 32'(sfc_if.is_halted), 32'd0);
        step();
        check("halted", 32'(sfc_if.is_halted), 32'd1);
        check("halted_outs", 32'(outs), 32'(OutHalt));
        check("halted_cycle", sfc_if.cycle_count, 32'd9);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        #1 check("halted_ignore_outs", 32'(outs), 32'(OutHalt));
        step();
        step();
        check("halted_cycle_frozen", sfc_if.cycle_count, 32'd9);
        check("halted_stall_frozen", sfc_if.stall_count, 32'd4);
        check("halted_flush_frozen", sfc_if.flush_count, 32'd2);
        check("halted_sticky", 32'(sfc_if.is_halted), 32'd1);

        // Asynchronous reset while halted
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("rst_halt_halted", 32'(sfc_if.is_halted), 32'd0);
        check("rst_halt_cycle", sfc_if.cycle_count, 32'd0);
        check("rst_halt_stall", sfc_if.stall_count, 32'd0);
        check("rst_halt_flush", sfc_if.flush_count, 32'd0);
        check("rst_halt_outs", 32'(outs), 32'(OutDef));
        @(negedge clk);
        reset = 1'b1;

        // Halt drain stretched by two busy cycles
        #1 drive(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        #1 check("drain_busy_outs", 32'(outs), 32'(OutBusy));
        step();
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("drain_resume_outs", 32'(outs), 32'(OutDrain));
        step();
        check("drain_busy_not_halted", 32'(sfc_if.is_halted), 32'd0);
        step();
        check("drain_busy_halted", 32'(sfc_if.is_halted), 32'd1);
        check("drain_busy_cycle", sfc_if.cycle_count, 32'd5);
        check("drain_busy_stall", sfc_if.stall_count, 32'd2);

        // Asynchronous reset mid-drain
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        #1 drive(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        #1;
        check("rst_drain_halted", 32'(sfc_if.is_halted), 32'd0);
        check("rst_drain_cycle", sfc_if.cycle_count, 32'd0);
        check("rst_drain_outs", 32'(outs), 32'(OutDef));
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        check("post_rst_not_halted", 32'(sfc_if.is_halted), 32'd0);
        check("post_rst_cycle", sfc_if.cycle_count, 32'd3);
        check("post_rst_outs", 32'(outs), 32'(OutDef));

        // 4-bit counter saturation
        repeat (11) step();
        check("sat_cycle_14", 32'(sfc4_if.cycle_count), 32'd14);
        step();
        check("sat_cycle_15", 32'(sfc4_if.cycle_count), 32'd15);
        step();
        step();
        check("sat_cycle_hold", 32'(sfc4_if.cycle_count), 32'd15);
        check("wide_cycle", sfc_if.cycle_count, 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
